// File: rtl/mode_pkg.sv
// Shared definitions for the mode manager: display character codes, the
// scheduler state encoding and the per-mode bus widths.
package mode_pkg;

  localparam int LED_W     = 16;
  localparam int SEG_W     = 20;
  localparam int MAX_MODES = 8;

  localparam logic [4:0] C_HYPHEN = 5'd10;
  localparam logic [4:0] C_E      = 5'd11;
  localparam logic [4:0] C_r      = 5'd12;
  localparam logic [4:0] C_L      = 5'd13;
  localparam logic [4:0] C_o      = 5'd17;
  localparam logic [4:0] C_b      = 5'd18;
  localparam logic [4:0] C_d      = 5'd19;
  localparam logic [4:0] C_BLANK  = 5'd31;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } mgr_state_t;

  // Menu screen: "--" then a blank, then the 1-based mode number.
  function automatic logic [SEG_W-1:0] menu_seg(input logic [2:0] sel);
    return {C_HYPHEN, C_HYPHEN, C_BLANK, {2'b00, sel} + 5'd1};
  endfunction

endpackage

// File: rtl/press_hold_timer.sv
// Saturating run-length counter: fire is high on the N-th and every later
// consecutive cycle that level is high. Any low cycle restarts the count.
module press_hold_timer #(
  parameter int unsigned N = 8,
  parameter int          W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic fire
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || !level) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign fire = level && (count_reg == LAST);

endmodule

// File: rtl/mode_manager.sv
// Menu/scheduler sharing LEDs, display and buttons among NUM_MODES game modes.
// Define MODE_MGR_IDLE_TIMEOUT_EN to add the RUN idle auto-exit.
module mode_manager
  import mode_pkg::*;
#(
  parameter int          NUM_MODES           = 4,
  parameter int unsigned LONG_PRESS_CYCLES   = 200_000_000,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 32'd3_000_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_confirm,
  input  logic [NUM_MODES*LED_W-1:0] mode_led_bus,
  input  logic [NUM_MODES*SEG_W-1:0] mode_seg_bus,
  output logic [NUM_MODES-1:0]       mode_active,
  output logic                       mode_btn_up,
  output logic                       mode_btn_down,
  output logic                       mode_btn_left,
  output logic                       mode_btn_right,
  output logic                       mode_btn_confirm,
  output logic [LED_W-1:0]           led,
  output logic [SEG_W-1:0]           seg_data,
  output logic [2:0]                 mode_sel
);

  localparam logic [2:0] SEL_LAST = 3'(NUM_MODES - 1);

  mgr_state_t           state_reg;
  logic [2:0]           mode_sel_reg, sel_next;
  logic [NUM_MODES-1:0] mode_active_reg;
  logic [4:0]           btn_out_reg, prev_reg, btn_now, edges;
  logic                 edge_en_reg;
  logic [LED_W-1:0]     led_reg;
  logic [SEG_W-1:0]     seg_reg;
  logic                 inc_edge, dec_edge, confirm_edge;
  logic                 long_fire, idle_fire;

  // Padded to MAX_MODES so a 3-bit mode_sel always indexes in range.
  logic [LED_W-1:0] led_arr [MAX_MODES];
  logic [SEG_W-1:0] seg_arr [MAX_MODES];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_MODES; gi++) begin : g_slice
      if (gi < NUM_MODES) begin : g_used
        assign led_arr[gi] = mode_led_bus[gi*LED_W +: LED_W];
        assign seg_arr[gi] = mode_seg_bus[gi*SEG_W +: SEG_W];
      end else begin : g_pad
        assign led_arr[gi] = '0;
        assign seg_arr[gi] = '0;
      end
    end
  endgenerate

  assign btn_now      = {btn_up, btn_down, btn_left, btn_right, btn_confirm};
  assign edges        = btn_now & ~prev_reg & {5{edge_en_reg}};
  assign inc_edge     = edges[4] | edges[2];
  assign dec_edge     = edges[3] | edges[1];
  assign confirm_edge = edges[0];

  always_comb begin
    sel_next = mode_sel_reg;
    if (inc_edge && !dec_edge) begin
      sel_next = (mode_sel_reg == SEL_LAST) ? 3'd0 : mode_sel_reg + 3'd1;
    end else if (dec_edge && !inc_edge) begin
      sel_next = (mode_sel_reg == 3'd0) ? SEL_LAST : mode_sel_reg - 3'd1;
    end
  end

  press_hold_timer #(.N(LONG_PRESS_CYCLES)) u_long_press (
    .clk   (clk),
    .reset (reset),
    .level ((state_reg == RUN) && btn_confirm),
    .fire  (long_fire)
  );

`ifdef MODE_MGR_IDLE_TIMEOUT_EN
  // Level is low outside RUN, so the count is already clear on RUN entry.
  press_hold_timer #(.N(IDLE_TIMEOUT_CYCLES), .W(32)) u_idle (
    .clk   (clk),
    .reset (reset),
    .level ((state_reg == RUN) && !(|btn_now)),
    .fire  (idle_fire)
  );
`else
  assign idle_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= MENU;
      mode_sel_reg    <= 3'd0;
      mode_active_reg <= '0;
      btn_out_reg     <= '0;
      led_reg         <= 16'h0001;
      seg_reg         <= menu_seg(3'd0);
      prev_reg        <= '0;
      edge_en_reg     <= 1'b0;
    end else begin
      prev_reg    <= btn_now;
      edge_en_reg <= 1'b1;
      case (state_reg)
        MENU: begin
          if (confirm_edge) begin
            state_reg       <= ARM;
            mode_active_reg <= NUM_MODES'(1) << mode_sel_reg;
          end else begin
            mode_sel_reg <= sel_next;
            led_reg      <= LED_W'(1) << sel_next;
            seg_reg      <= menu_seg(sel_next);
          end
        end
        ARM: begin
          // Holding here until release keeps the launching press from the mode.
          if (!btn_confirm) begin
            state_reg   <= RUN;
            btn_out_reg <= btn_now;
            led_reg     <= led_arr[mode_sel_reg];
            seg_reg     <= seg_arr[mode_sel_reg];
          end
        end
        RUN: begin
          if (long_fire) begin
            state_reg       <= DRAIN;
            mode_active_reg <= '0;
            btn_out_reg     <= '0;
            led_reg         <= '0;
            seg_reg         <= {4{C_HYPHEN}};
          end else if (idle_fire) begin
            state_reg       <= MENU;
            mode_active_reg <= '0;
            btn_out_reg     <= '0;
            led_reg         <= LED_W'(1) << mode_sel_reg;
            seg_reg         <= menu_seg(mode_sel_reg);
          end else begin
            btn_out_reg <= btn_now;
            led_reg     <= led_arr[mode_sel_reg];
            seg_reg     <= seg_arr[mode_sel_reg];
          end
        end
        DRAIN: begin
          if (!btn_confirm) begin
            state_reg <= MENU;
            led_reg   <= LED_W'(1) << mode_sel_reg;
            seg_reg   <= menu_seg(mode_sel_reg);
          end
        end
        default: state_reg <= MENU;
      endcase
    end
  end

  assign mode_active      = mode_active_reg;
  assign mode_btn_up      = btn_out_reg[4];
  assign mode_btn_down    = btn_out_reg[3];
  assign mode_btn_left    = btn_out_reg[2];
  assign mode_btn_right   = btn_out_reg[1];
  assign mode_btn_confirm = btn_out_reg[0];
  assign led              = led_reg;
  assign seg_data         = seg_reg;
  assign mode_sel         = mode_sel_reg;

endmodule

// File: tb/tb_mode_manager.sv
// Self-checking bench for mode_manager: menu vector table, hand sequences for
// ARM/RUN/DRAIN/reset/idle corners, then random stimulus against a reference model.
module tb_mode_manager;

  localparam int NM   = 4;
  localparam int LONG = 8;
  localparam int IDLE = 20;
`ifdef MODE_MGR_IDLE_TIMEOUT_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_UP   = 5'b10000;
  localparam logic [4:0] B_DN   = 5'b01000;
  localparam logic [4:0] B_LT   = 5'b00100;
  localparam logic [4:0] B_RT   = 5'b00010;
  localparam logic [4:0] B_CF   = 5'b00001;
  localparam logic [19:0] SEG_DRAIN = {5'd10, 5'd10, 5'd10, 5'd10};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_confirm = 1'b0;
  logic [NM*16-1:0] mode_led_bus = '0;
  logic [NM*20-1:0] mode_seg_bus = '0;
  logic [NM-1:0] mode_active;
  logic mode_btn_up, mode_btn_down, mode_btn_left, mode_btn_right, mode_btn_confirm;
  logic [15:0] led;
  logic [19:0] seg_data;
  logic [2:0] mode_sel;

  always #5 clk = ~clk;

  mode_manager #(.NUM_MODES(NM), .LONG_PRESS_CYCLES(LONG), .IDLE_TIMEOUT_CYCLES(IDLE)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_confirm(btn_confirm),
    .mode_led_bus(mode_led_bus), .mode_seg_bus(mode_seg_bus),
    .mode_active(mode_active),
    .mode_btn_up(mode_btn_up), .mode_btn_down(mode_btn_down), .mode_btn_left(mode_btn_left),
    .mode_btn_right(mode_btn_right), .mode_btn_confirm(mode_btn_confirm),
    .led(led), .seg_data(seg_data), .mode_sel(mode_sel)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase of the scheduler plus run-length counts of held/quiet cycles.
  typedef enum int {P_MENU, P_ARM, P_RUN, P_DRAIN} phase_e;
  phase_e      m_phase = P_MENU;
  int          m_sel = 0, m_hold = 0, m_quiet = 0;
  bit          m_valid = 1'b0;
  logic [4:0]  m_prev = '0;
  logic [4:0]  m_btn = '0;
  logic [15:0] m_led = 16'h0001;
  logic [19:0] m_seg = 20'd0;

  function automatic logic [19:0] ms(input int n);
    return {5'd10, 5'd10, 5'd31, 5'(n + 1)};
  endfunction

  task automatic model_step();
    logic [4:0] b, rise;
    int delta;
    b = {btn_up, btn_down, btn_left, btn_right, btn_confirm};
    if (reset) begin
      m_phase = P_MENU; m_sel = 0; m_hold = 0; m_quiet = 0; m_valid = 1'b0; m_prev = b;
    end else begin
      rise = m_valid ? (b & ~m_prev) : 5'b0;
      m_prev = b;
      m_valid = 1'b1;
      case (m_phase)
        P_MENU: begin
          if (rise[0]) m_phase = P_ARM;
          else begin
            delta = int'(rise[4] | rise[2]) - int'(rise[3] | rise[1]);
            m_sel = (m_sel + delta + NM) % NM;
          end
        end
        P_ARM:   if (!b[0]) m_phase = P_RUN;
        P_RUN: begin
          m_hold  = b[0] ? m_hold + 1 : 0;
          m_quiet = (b == 5'b0) ? m_quiet + 1 : 0;
          if (m_hold >= LONG) m_phase = P_DRAIN;
          else if (IDLE_EN && m_quiet >= IDLE) m_phase = P_MENU;
        end
        default: if (!b[0]) m_phase = P_MENU;
      endcase
    end
    if (m_phase != P_RUN) begin m_hold = 0; m_quiet = 0; end
    m_btn = (m_phase == P_RUN) ? b : 5'b0;
    case (m_phase)
      P_RUN: begin
        m_led = mode_led_bus[m_sel*16 +: 16];
        m_seg = mode_seg_bus[m_sel*20 +: 20];
      end
      P_DRAIN: begin m_led = 16'h0000; m_seg = SEG_DRAIN; end
      default: begin m_led = 16'(1) << m_sel; m_seg = ms(m_sel); end
    endcase
  endtask

  task automatic check_model(input string name);
    logic [NM-1:0] exp_act;
    logic [4:0] got_btn;
    exp_act = (m_phase == P_ARM || m_phase == P_RUN) ? (NM'(1) << m_sel) : '0;
    got_btn = {mode_btn_up, mode_btn_down, mode_btn_left, mode_btn_right, mode_btn_confirm};
    vectors++;
    if (mode_active !== exp_act || got_btn !== m_btn || led !== m_led ||
        seg_data !== m_seg || mode_sel !== 3'(m_sel)) begin
      miscompares++;
      $display("FAIL %s: got act=%b btn=%b led=%h seg=%h sel=%0d, expected act=%b btn=%b led=%h seg=%h sel=%0d",
               name, mode_active, got_btn, led, seg_data, mode_sel,
               exp_act, m_btn, m_led, m_seg, m_sel);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] b, input string name);
    reset = r;
    {btn_up, btn_down, btn_left, btn_right, btn_confirm} = b;
    @(posedge clk);
    model_step();
    #1;
    check_model(name);
  endtask

  typedef struct {
    logic [4:0]  btn;
    logic [2:0]  sel;
    logic [15:0] led;
    logic [19:0] seg;
  } vec_t;

  vec_t vec [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{B_NONE,      3'd0, 16'h0001, ms(0)};
    vec[1]  = '{B_DN,        3'd3, 16'h0008, ms(3)};
    vec[2]  = '{B_NONE,      3'd3, 16'h0008, ms(3)};
    vec[3]  = '{B_DN,        3'd2, 16'h0004, ms(2)};
    vec[4]  = '{B_NONE,      3'd2, 16'h0004, ms(2)};
    vec[5]  = '{B_DN,        3'd1, 16'h0002, ms(1)};
    vec[6]  = '{B_NONE,      3'd1, 16'h0002, ms(1)};
    vec[7]  = '{B_UP,        3'd2, 16'h0004, ms(2)};
    vec[8]  = '{B_NONE,      3'd2, 16'h0004, ms(2)};
    vec[9]  = '{B_UP | B_DN, 3'd2, 16'h0004, ms(2)};
    vec[10] = '{B_NONE,      3'd2, 16'h0004, ms(2)};
    vec[11] = '{B_LT,        3'd3, 16'h0008, ms(3)};
    vec[12] = '{B_NONE,      3'd3, 16'h0008, ms(3)};
    vec[13] = '{B_LT,        3'd0, 16'h0001, ms(0)};
    vec[14] = '{B_NONE,      3'd0, 16'h0001, ms(0)};
    vec[15] = '{B_RT,        3'd3, 16'h0008, ms(3)};
    vec[16] = '{B_NONE,      3'd3, 16'h0008, ms(3)};
    vec[17] = '{B_UP,        3'd0, 16'h0001, ms(0)};
    vec[18] = '{B_UP,        3'd0, 16'h0001, ms(0)};
    vec[19] = '{B_NONE,      3'd0, 16'h0001, ms(0)};

    // Reset with up held; the first cycle after reset must not see an edge.
    for (int i = 0; i < 3; i++) step(1'b1, B_UP, "reset");
    check_val("reset_led", 32'(led), 32'h0001);
    check_val("reset_seg", 32'(seg_data), 32'({5'd10, 5'd10, 5'd31, 5'd1}));
    check_val("reset_active", 32'(mode_active), 32'd0);
    step(1'b0, B_UP, "first_cycle");
    check_val("no_edge_after_reset", 32'(mode_sel), 32'd0);
    step(1'b0, B_NONE, "idle");

    for (int i = 0; i < 20; i++) begin
      step(1'b0, vec[i].btn, "table");
      check_val($sformatf("tbl%0d_sel", i), 32'(mode_sel), 32'(vec[i].sel));
      check_val($sformatf("tbl%0d_led", i), 32'(led), 32'(vec[i].led));
      check_val($sformatf("tbl%0d_seg", i), 32'(seg_data), 32'(vec[i].seg));
      check_val($sformatf("tbl%0d_act", i), 32'(mode_active), 32'd0);
    end

    // Launch mode 2 with a 3-cycle confirm press.
    mode_seg_bus[40 +: 20] = 20'hABCDE;
    step(1'b0, B_DN, "nav"); step(1'b0, B_NONE, "nav");
    step(1'b0, B_DN, "nav"); step(1'b0, B_NONE, "nav");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, B_CF, "arm");
      check_val("arm_active", 32'(mode_active), 32'b0100);
      check_val("arm_btn_confirm", 32'(mode_btn_confirm), 32'd0);
    end
    step(1'b0, B_NONE, "release");
    check_val("run_seg", 32'(seg_data), 32'hABCDE);
    check_val("run_active", 32'(mode_active), 32'b0100);
    mode_seg_bus[40 +: 20] = 20'h12345;
    step(1'b0, B_NONE, "run_bus");
    check_val("run_seg_update", 32'(seg_data), 32'h12345);
    step(1'b0, B_UP, "run_up");
    check_val("run_btn_up", 32'(mode_btn_up), 32'd1);
    check_val("run_sel_frozen", 32'(mode_sel), 32'd2);
    step(1'b0, B_NONE, "run_up_off");
    check_val("run_btn_up_off", 32'(mode_btn_up), 32'd0);

    // Long press: DRAIN on the LONG-th held cycle, MENU after release.
    for (int i = 1; i <= LONG; i++) begin
      step(1'b0, B_CF, "long");
      check_val($sformatf("long%0d_active", i), 32'(mode_active), (i < LONG) ? 32'b0100 : 32'd0);
    end
    check_val("drain_seg", 32'(seg_data), 32'(SEG_DRAIN));
    check_val("drain_led", 32'(led), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, B_CF, "drain_hold");
    check_val("drain_still", 32'(seg_data), 32'(SEG_DRAIN));
    step(1'b0, B_NONE, "drain_release");
    check_val("menu_sel_kept", 32'(mode_sel), 32'd2);
    check_val("menu_led", 32'(led), 32'h0004);

    // Reset while running.
    step(1'b0, B_CF, "arm2"); step(1'b0, B_NONE, "run2");
    check_val("run2_active", 32'(mode_active), 32'b0100);
    step(1'b1, B_NONE, "reset_run");
    check_val("reset_run_active", 32'(mode_active), 32'd0);
    check_val("reset_run_sel", 32'(mode_sel), 32'd0);
    step(1'b0, B_NONE, "after_reset");

    // Idle timeout (only exits RUN when the feature is built in).
    step(1'b0, B_CF, "arm3"); step(1'b0, B_NONE, "run3");
    for (int i = 1; i <= IDLE; i++) begin
      step(1'b0, B_NONE, "idle");
      check_val($sformatf("idle%0d_active", i), 32'(mode_active),
                (IDLE_EN && i == IDLE) ? 32'd0 : 32'b0001);
    end
    step(1'b1, B_NONE, "reset_idle"); step(1'b0, B_NONE, "after_reset");
    step(1'b0, B_UP, "nav"); step(1'b0, B_NONE, "nav");
    step(1'b0, B_CF, "arm4"); step(1'b0, B_NONE, "run4");
    for (int i = 0; i < 14; i++) step(1'b0, B_NONE, "idle_pre");
    step(1'b0, B_LT, "idle_pulse");
    check_val("idle_pulse_fwd", 32'(mode_btn_left), 32'd1);
    for (int i = 1; i <= IDLE; i++) begin
      step(1'b0, B_NONE, "idle_post");
      check_val($sformatf("idle_post%0d_active", i), 32'(mode_active),
                (IDLE_EN && i == IDLE) ? 32'd0 : 32'b0010);
    end

    // Random stimulus against the model.
    begin
      int conf_left;
      logic [4:0] b;
      logic r;
      conf_left = 0;
      step(1'b1, B_NONE, "rand_reset");
      for (int c = 0; c < 3000; c++) begin
        mode_led_bus = {$urandom, $urandom};
        mode_seg_bus = {16'($urandom), $urandom, $urandom};
        b = 5'b0;
        for (int k = 1; k < 5; k++) b[k] = ($urandom_range(0, 11) == 0);
        if (conf_left > 0) begin
          b[0] = 1'b1;
          conf_left--;
        end else if ($urandom_range(0, 14) == 0) begin
          b[0] = 1'b1;
          conf_left = int'($urandom_range(1, 12)) - 1;
        end
        if (c % 250 >= 220) begin
          b = 5'b0;
          conf_left = 0;
        end
        r = ($urandom_range(0, 399) == 0);
        step(r, b, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
